fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the RISC-V core. It replaces the free-running PC register and its direct instruction lookup. It owns the fetch PC and issues word requests to instruction memory, at most one outstanding at a time. Returned words are buffered with their PCs in a DEPTH-entry queue and handed to decode over a valid/ready handshake. Branch, jal and jalr redirects from execute flush the queue and discard any stale in-flight response.

---
 rtl/core_pkg.sv | 19 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types for the instruction-fetch front end.
//   fetch_state_t : fetch FSM states (IDLE / WAIT / DROP)
//   fetch_entry_t : one fetch-queue entry, instruction word plus its PC
package core_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE,  // no request outstanding
      WAIT,  // request outstanding, its response will be queued
      DROP   // request outstanding, its response will be discarded
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic DEPTH x WIDTH in-order queue.
//   clk, n_rst : clock, synchronous active-low reset
//   push/wdata : write an entry at the tail
//   pop        : remove the head entry (ignored when empty)
//   flush      : drop all entries (overrides push/pop)
//   rdata      : head entry
//   count      : current occupancy, full/empty flags
// Push and pop in the same cycle are accepted at any occupancy, including full.
module sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!n_rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//   clk, n_rst        : clock, synchronous active-low reset
//   imem_req/addr     : word request to instruction memory (one outstanding max)
//   imem_rdata/rvalid : response from instruction memory
//   redirect_valid/pc : control-flow redirect from execute (flushes everything)
//   misalign_err      : one-cycle pulse after a redirect to a non-word address
//   instr_valid/instr/instr_pc, instr_ready : queue head towards decode
module fetch_unit
   import core_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     DEPTH    = 4
) (
   input  logic            clk,
   input  logic            n_rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_rvalid,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            misalign_err,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_t    state;
   fetch_state_t    state_nx;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_pc;    // address of the outstanding request
   logic [CW-1:0]   count;
   logic            fifo_full;
   logic            fifo_empty;
   logic            deq;
   logic            resp;
   logic            push;
   logic            issue;
   logic [CW:0]     occ;       // occupancy after this cycle's push/pop
   fetch_entry_t    wr_entry;
   fetch_entry_t    rd_entry;

   assign instr_valid = ~fifo_empty;
   assign instr       = rd_entry.instr;
   assign instr_pc    = rd_entry.pc;
   assign deq         = instr_valid & instr_ready;
   assign resp        = imem_rvalid & (state == WAIT);
   assign occ         = {1'b0, count} + (CW+1)'(resp) - (CW+1)'(deq);

   // A full queue with a response in flight cannot arise (issue reserves the
   // slot), the gate only keeps the queue coherent if that ever changes.
   assign push = resp & ~redirect_valid & (~fifo_full | deq);

   assign wr_entry.pc    = req_pc;
   assign wr_entry.instr = imem_rdata;

   assign imem_addr = fetch_pc;
   assign imem_req  = issue;

   always_comb begin
      issue    = n_rst & ~redirect_valid
               & ((state == IDLE) | imem_rvalid)
               & (occ < (CW+1)'(DEPTH))
               & ((state != DROP) | imem_rvalid);
      state_nx = state;
      if (redirect_valid) begin
         // A request still in flight (from WAIT or an earlier DROP) must be
         // swallowed, otherwise it would be taken as the next response.
         if ((state != IDLE) && !imem_rvalid) state_nx = DROP;
         else                                 state_nx = IDLE;
      end else if (issue) begin
         state_nx = WAIT;
      end else if (imem_rvalid && (state != IDLE)) begin
         state_nx = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state        <= IDLE;
         fetch_pc     <= RESET_PC;
         req_pc       <= RESET_PC;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nx;
         misalign_err <= redirect_valid & (|redirect_pc[1:0]);
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         end else if (issue) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            req_pc   <= fetch_pc;
         end
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_queue (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (push),
      .wdata (wr_entry),
      .pop   (deq),
      .flush (redirect_valid),
      .rdata (rd_entry),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        misalign_err;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN     (32),
      .RESET_PC (RST_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_rvalid    (imem_rvalid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .misalign_err   (misalign_err),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   int checks = 0;
   int errors = 0;

   // samples taken mid-cycle
   logic        s_req, s_valid, s_mis;
   logic [31:0] s_addr, s_instr, s_pc;

   // reference model: expected fetch/deliver addresses, words held, memory
   logic [31:0] m_fetch, m_head, m_oaddr;
   int          m_held;
   bit          m_out, m_stale, m_mis;
   int          m_olat;
   int          lat_min = 0;
   int          lat_max = 0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit rv, deq, incoming, exp_req;
      int occ;
      @(negedge clk);
      s_req   = imem_req;   s_addr = imem_addr; s_valid = instr_valid;
      s_instr = instr;      s_pc   = instr_pc;  s_mis   = misalign_err;
      rv = imem_rvalid;
      if (!n_rst) begin
         chk("req_in_reset", 32'(s_req), 32'd0);
         m_fetch = RST_PC; m_head = RST_PC; m_held = 0;
         m_out = 0; m_stale = 0; m_mis = 0;
      end else begin
         deq      = s_valid && instr_ready;
         incoming = rv && m_out && !m_stale;
         occ      = m_held + int'(incoming) - int'(deq);
         exp_req  = !redirect_valid && (!m_out || rv) && (occ < DEPTH);
         chk("imem_req", 32'(s_req), 32'(exp_req));
         if (s_req) chk("imem_addr", s_addr, m_fetch);
         chk("instr_valid", 32'(s_valid), 32'(m_held > 0));
         if (s_valid) begin
            chk("instr_pc", s_pc, m_head);
            chk("instr", s_instr, word_at(s_pc));
         end
         chk("misalign_err", 32'(s_mis), 32'(m_mis));
         // what the next edge should do
         m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (rv && m_out) begin m_out = 0; m_stale = 0; end
         if (redirect_valid) begin
            m_held  = 0;
            m_fetch = {redirect_pc[31:2], 2'b00};
            m_head  = m_fetch;
            if (m_out) m_stale = 1;
         end else begin
            m_held = occ;
            if (deq) m_head = m_head + 32'd4;
            if (s_req) begin
               m_out   = 1; m_stale = 0; m_oaddr = s_addr;
               m_olat  = $urandom_range(lat_max, lat_min);
               m_fetch = m_fetch + 32'd4;
            end
         end
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (m_out) begin
         if (m_olat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_at(m_oaddr);
         end else begin
            m_olat--;
         end
      end
   endtask

   task automatic do_reset();
      n_rst = 1'b0; redirect_valid = 1'b0;
      tick(); tick();
      n_rst = 1'b1;
   endtask

   initial begin
      int n;
      bit found;
      n_rst = 1'b0; imem_rdata = '0; imem_rvalid = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

      // reset release, 1-cycle memory, streaming
      do_reset();
      tick(); chk("d1_req0", 32'(s_req), 32'd1); chk("d1_addr0", s_addr, 32'h0);
      chk("d1_valid0", 32'(s_valid), 32'd0); chk("d1_mis0", 32'(s_mis), 32'd0);
      tick(); chk("d1_addr1", s_addr, 32'h4); chk("d1_valid1", 32'(s_valid), 32'd0);
      tick(); chk("d1_addr2", s_addr, 32'h8); chk("d1_valid2", 32'(s_valid), 32'd1);
      chk("d1_pc2", s_pc, 32'h0);

      // backpressure fills the queue, stray response in IDLE, then drain
      instr_ready = 1'b0;
      do_reset();
      n = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (s_req) begin chk("d2_addr", s_addr, 32'(n * 4)); n++; end
      end
      chk("d2_nreq", 32'(n), 32'd4);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick(); chk("d2_stray_req", 32'(s_req), 32'd0);
      instr_ready = 1'b1;
      tick(); chk("d2_pop0", s_pc, 32'h0); chk("d2_refill_req", 32'(s_req), 32'd1);
      chk("d2_refill_addr", s_addr, 32'h10);
      tick(); chk("d2_pop1", s_pc, 32'h4);
      tick(); chk("d2_pop2", s_pc, 32'h8);
      tick(); chk("d2_pop3", s_pc, 32'hC);

      // redirect while waiting, stale response arrives next cycle
      lat_min = 1; lat_max = 1;
      do_reset();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      tick(); chk("d3_req", 32'(s_req), 32'd1); chk("d3_addr", s_addr, 32'h100);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (s_valid) begin found = 1; chk("d3_first_pc", s_pc, 32'h100); end
      end
      chk("d3_found", 32'(found), 32'd1);

      // redirect coincident with a response
      lat_min = 0; lat_max = 0;
      do_reset();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      tick(); chk("d4_valid", 32'(s_valid), 32'd0); chk("d4_req", 32'(s_req), 32'd1);
      chk("d4_addr", s_addr, 32'h200);

      // misaligned redirect
      do_reset();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      tick();
      redirect_valid = 1'b0;
      tick(); chk("d5_mis_hi", 32'(s_mis), 32'd1); chk("d5_addr", s_addr, 32'h100);
      tick(); chk("d5_mis_lo", 32'(s_mis), 32'd0);

      // PC wrap at the top of the address space
      do_reset();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      tick(); chk("d7_addr0", s_addr, 32'hFFFF_FFF8);
      tick(); chk("d7_addr1", s_addr, 32'hFFFF_FFFC);
      tick(); chk("d7_addr2", s_addr, 32'h0);
      for (int i = 0; i < 6; i++) tick();

      // reset mid-operation with three entries queued and one in flight
      instr_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      tick(); chk("d6_valid", 32'(s_valid), 32'd0); chk("d6_req", 32'(s_req), 32'd1);
      chk("d6_addr", s_addr, RST_PC);

      // randomized traffic against the model
      lat_min = 0; lat_max = 3;
      for (int i = 0; i < 3000; i++) begin
         instr_ready    = ($urandom_range(9, 0) < 7);
         redirect_valid = ($urandom_range(15, 0) == 0);
         case ($urandom_range(2, 0))
            0:       redirect_pc = $urandom;
            1:       redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(31, 0));
            default: redirect_pc = 32'($urandom_range(255, 0));
         endcase
         n_rst = ($urandom_range(199, 0) != 0);
         tick();
      end
      n_rst = 1'b1; redirect_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
